// File: rtl/packet_flit_sender.sv
`default_nettype none
// ============================================================================
//  Module      : packet_flit_sender (with package types)
//  Description : Buffers one packet of up to MAX_NUM_OF_FLIT flits, serialises
//                it onto a valid/ready flit link, waits for a matching ack and
//                reports success or expiry with a one-cycle done pulse.
//                Optional macro PACKET_SENDER_RETRY_EN enables up to MAX_RETRY
//                full retransmissions on ack expiry.
//  Revision    : 1.0 - initial release
// ============================================================================

package types;
    typedef logic [7:0] flit_t;
    typedef logic [7:0] packet_id_t;
endpackage

module packet_flit_sender #(
    parameter int MAX_NUM_OF_FLIT = 8,
    parameter int EXPIRE_TIME     = 100,
    parameter int MAX_RETRY       = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_valid,
    output logic                               load_ready,
    input  logic [$bits(types::flit_t)-1:0]      load_flit,
    input  logic                               load_last,
    input  logic [$bits(types::packet_id_t)-1:0] load_packet_id,
    output logic                               tx_valid,
    input  logic                               tx_ready,
    output logic [$bits(types::flit_t)-1:0]      tx_flit,
    input  logic                               ack_valid,
    input  logic [$bits(types::packet_id_t)-1:0] ack_packet_id,
    output logic                               done_valid,
    output logic                               done_success,
    output logic                               busy
);

    localparam int c_FLIT_W = $bits(types::flit_t);
    localparam int c_ID_W   = $bits(types::packet_id_t);
    localparam int c_IDX_W  = (MAX_NUM_OF_FLIT > 1) ? $clog2(MAX_NUM_OF_FLIT) : 1;
    localparam int c_TMR_W  = (EXPIRE_TIME > 1) ? $clog2(EXPIRE_TIME) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX    = c_IDX_W'(MAX_NUM_OF_FLIT - 1);
    localparam logic [c_TMR_W-1:0] c_EXPIRE_LAST = c_TMR_W'(EXPIRE_TIME - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SEND     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_FLIT_W-1:0]  r_buf [MAX_NUM_OF_FLIT];
    logic [c_ID_W-1:0]    r_packet_id;
    logic [c_IDX_W-1:0]   r_wr_index, w_wr_index_nxt;
    logic [c_IDX_W-1:0]   r_tail_index, w_tail_nxt;
    logic [c_IDX_W-1:0]   r_send_index, w_send_nxt, w_send_inc;
    logic [c_TMR_W-1:0]   r_timer, w_timer_nxt;
    logic [c_FLIT_W-1:0]  r_tx_flit, w_tx_flit_nxt;
    logic                 r_load_ready, r_tx_valid, r_done_valid, r_done_success, r_busy;
    logic                 w_success_nxt;
    logic                 w_load_fire, w_ack_match, w_buf_we, w_capture_id;

`ifdef PACKET_SENDER_RETRY_EN
    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [c_RETRY_W-1:0] r_retry_cnt, w_retry_nxt;
`else
    // MAX_RETRY has no function in this build.
    logic w_unused_retry;
    assign w_unused_retry = (MAX_RETRY > 0);
`endif

    assign w_load_fire = load_valid && r_load_ready;
    assign w_ack_match = ack_valid && (ack_packet_id == r_packet_id);
    assign w_send_inc  = r_send_index + 1'b1;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_index_nxt = r_wr_index;
        w_tail_nxt     = r_tail_index;
        w_send_nxt     = r_send_index;
        w_timer_nxt    = r_timer;
        w_tx_flit_nxt  = r_tx_flit;
        w_success_nxt  = 1'b0;
        w_buf_we       = 1'b0;
        w_capture_id   = 1'b0;
`ifdef PACKET_SENDER_RETRY_EN
        w_retry_nxt    = r_retry_cnt;
`endif
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (w_load_fire) begin
                    w_buf_we     = 1'b1;
                    w_capture_id = (r_state == S_IDLE);
                    // A full buffer terminates the packet even without load_last.
                    if (load_last || (r_wr_index == c_LAST_IDX)) begin
                        w_tail_nxt     = r_wr_index;
                        w_wr_index_nxt = '0;
                        w_send_nxt     = '0;
                        // Flit 0 may be the one being written this very cycle.
                        w_tx_flit_nxt  = (r_wr_index == '0) ? load_flit : r_buf[0];
                        w_state_nxt    = S_SEND;
                    end else begin
                        w_wr_index_nxt = r_wr_index + 1'b1;
                        w_state_nxt    = S_LOAD;
                    end
                end
            end
            S_SEND: begin
                if (r_tx_valid && tx_ready) begin
                    if (r_send_index == r_tail_index) begin
                        w_send_nxt  = '0;
                        w_timer_nxt = '0;
                        w_state_nxt = S_WAIT_ACK;
                    end else begin
                        w_send_nxt    = w_send_inc;
                        w_tx_flit_nxt = r_buf[w_send_inc];
                    end
                end
            end
            S_WAIT_ACK: begin
                w_timer_nxt = r_timer + 1'b1;
                // A matching ack takes priority over expiry in the same cycle.
                if (w_ack_match) begin
                    w_success_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else if (r_timer == c_EXPIRE_LAST) begin
`ifdef PACKET_SENDER_RETRY_EN
                    if (r_retry_cnt < c_RETRY_W'(MAX_RETRY)) begin
                        w_retry_nxt   = r_retry_cnt + 1'b1;
                        w_timer_nxt   = '0;
                        w_send_nxt    = '0;
                        w_tx_flit_nxt = r_buf[0];
                        w_state_nxt   = S_SEND;
                    end else begin
                        w_state_nxt   = S_DONE;
                    end
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
`ifdef PACKET_SENDER_RETRY_EN
                w_retry_nxt = '0;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, indices, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wr_index     <= '0;
            r_tail_index   <= '0;
            r_send_index   <= '0;
            r_timer        <= '0;
            r_tx_flit      <= '0;
            r_load_ready   <= 1'b0;
            r_tx_valid     <= 1'b0;
            r_done_valid   <= 1'b0;
            r_done_success <= 1'b0;
            r_busy         <= 1'b0;
`ifdef PACKET_SENDER_RETRY_EN
            r_retry_cnt    <= '0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_wr_index     <= w_wr_index_nxt;
            r_tail_index   <= w_tail_nxt;
            r_send_index   <= w_send_nxt;
            r_timer        <= w_timer_nxt;
            r_tx_flit      <= w_tx_flit_nxt;
            r_load_ready   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            r_tx_valid     <= (w_state_nxt == S_SEND);
            r_done_valid   <= (w_state_nxt == S_DONE);
            r_done_success <= w_success_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
`ifdef PACKET_SENDER_RETRY_EN
            r_retry_cnt    <= w_retry_nxt;
`endif
        end
    end

    // Packet storage and id capture; contents are meaningless outside a packet.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wr_index] <= load_flit;
        end
        if (w_capture_id) begin
            r_packet_id <= load_packet_id;
        end
    end

    assign load_ready   = r_load_ready;
    assign tx_valid     = r_tx_valid;
    assign tx_flit      = r_tx_flit;
    assign done_valid   = r_done_valid;
    assign done_success = r_done_success;
    assign busy         = r_busy;

endmodule

`default_nettype wire

// File: doc/packet_flit_sender.md
Name: packet_flit_sender

Overview:
- Transmit-side counterpart of the per-packet reassembly buffer.
- Loads one packet of up to MAX_NUM_OF_FLIT flits into a local buffer and serialises it onto the flit link with valid/ready.
- Waits for an ack carrying the same packet_id; retransmits on timeout (optional).
- Reports success or failure to the issuing logic. Sits between the routing/packet-build logic and the link transmitter.

Parameters:
- MAX_NUM_OF_FLIT, 8, buffer depth in flits; index width $clog2(MAX_NUM_OF_FLIT).
- EXPIRE_TIME, 100, ack wait window in cycles; timer width $clog2(EXPIRE_TIME).
- MAX_RETRY, 3, number of retransmissions after the first send (used only with PACKET_SENDER_RETRY_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load_valid  in  1  load flit present.
- load_ready  out  1  sender accepts load flits.
- load_flit  in  $bits(types::flit_t)  flit to buffer.
- load_last  in  1  marks last flit of packet.
- load_packet_id  in  $bits(types::packet_id_t)  packet id, sampled with first flit only.
- tx_valid  out  1  outgoing flit valid.
- tx_ready  in  1  link accepts flit.
- tx_flit  out  $bits(types::flit_t)  outgoing flit.
- ack_valid  in  1  ack strobe.
- ack_packet_id  in  $bits(types::packet_id_t)  acked packet id.
- done_valid  out  1  one-cycle completion pulse.
- done_success  out  1  1 = acked, 0 = expired; valid only with done_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; load_ready=0 during reset, 1 in the first cycle after; tx_valid=0; tx_flit=0; done_valid=0; done_success=0; busy=0; tail_index, send_index, timer and retry_cnt all 0.
- All outputs are registered.
- States: IDLE, LOAD, SEND, WAIT_ACK, DONE.
- IDLE: load_ready=1.
  - Flit accepted (load_valid&&load_ready) -> store at index 0, capture packet_id.
  - If load_last, tail_index=0 and go to SEND; else go to LOAD.
- LOAD: load_ready=1. Each accepted flit is stored at the next index.
  - Accepted flit with load_last -> tail_index = that index, go to SEND.
  - The MAX_NUM_OF_FLIT-th flit is forced last (tail_index=MAX_NUM_OF_FLIT-1) regardless of load_last.
- load_ready=0 in SEND, WAIT_ACK and DONE.
- SEND: tx_valid rises the cycle after the last load flit is accepted.
  - tx_flit = buffer[send_index].
  - While tx_valid && !tx_ready, tx_flit and tx_valid are held stable.
  - On handshake, send_index increments; back-to-back flits at one per cycle while tx_ready=1.
  - Handshake of buffer[tail_index] -> tx_valid=0 next cycle, send_index=0, timer=0, go to WAIT_ACK.
- WAIT_ACK: timer increments every cycle.
  - ack_valid && ack_packet_id==captured id -> DONE with success=1.
  - Ack with non-matching id is ignored.
  - Acks outside WAIT_ACK (IDLE, LOAD, SEND, DONE) are ignored.
  - timer==EXPIRE_TIME-1 with no matching ack -> expiry (see Optional Feature).
  - Matching ack in the expiry cycle wins: success.
- DONE: lasts one cycle. done_valid=1, done_success per outcome, then IDLE. load_ready returns to 1 the cycle after done_valid.
- Minimum turnaround for an N-flit packet with tx_ready=1 and ack in the first WAIT_ACK cycle:
  - N load cycles, N send cycles, 1 wait cycle, 1 done cycle.
- Reset mid-operation discards the packet; no done pulse is issued.

Optional Feature:
- Macro: PACKET_SENDER_RETRY_EN.
- Defined:
  - On expiry, if retry_cnt < MAX_RETRY: retry_cnt++, timer=0, send_index=0, return to SEND and resend the whole buffer, same flits and same id.
  - Otherwise go to DONE with success=0.
  - retry_cnt clears on entry to IDLE.
- Not defined: expiry goes straight to DONE with success=0. No retry counter is synthesised. MAX_RETRY is unused.

Test Plan:
- Load 3 flits (0xA1,0xA2,0xA3, last on third), id=5, tx_ready=1, ack id=5 two cycles into WAIT_ACK -> tx emits A1,A2,A3 on consecutive cycles starting the cycle after load; done_valid=1, success=1; load_ready=1 next cycle.
- Same packet; tx_ready low for 4 cycles during flit 2 -> tx_flit holds 0xA2 with tx_valid=1 for all 4 cycles; no flit duplicated or skipped.
- Load 9 flits with load_last never asserted -> load_ready=0 after the 8th; 8 flits transmitted; the 9th is not accepted.
- Ack id=4 during WAIT_ACK for id=5, no other ack -> ignored. Without the macro: done_valid with success=0 exactly EXPIRE_TIME=100 cycles after WAIT_ACK entry. With the macro: 3 full resends, then success=0.
- Matching ack on the same cycle timer==99 -> success=1, no resend.
- rst asserted in the middle of SEND -> next cycle tx_valid=0, busy=0, no done pulse; then load_ready=1.
